// File: rtl/sp_ram_arbiter.sv
// sp_ram_arbiter: two-port round-robin arbiter/sequencer for a single-port RAM.
// Merges two requesters onto the RAM's one command port. A port can optionally
// lock the RAM for a burst of up to MAX_BURST consecutive grants. Read data
// comes back with a per-port valid one cycle after the read is granted.
//
// Optional feature macro: SP_RAM_ARB_FIXED_PRIO_EN
//   defined   -> contention in IDLE always grants port 0
//   undefined -> round-robin on contention (default)
//
// Ports:
//   clk_i, rst_i                       clock, synchronous active-high reset
//   pN_req_i/we_i/lock_i/addr_i/wdata_i  port N request, write flag, burst lock, address, data
//   pN_gnt_o                           combinational grant (req&gnt = access this cycle)
//   pN_rvalid_o, pN_rdata_o            registered read-valid pulse, read data
//   ram_rst_n_o                        RAM active-low reset (= ~rst_i)
//   ram_wr_en_o/rd_en_o/addr_o/wr_data_o  RAM command port (combinational)
//   ram_rd_data_i                      RAM registered read data
module sp_ram_arbiter #(
  parameter int unsigned ADDR_W    = 7,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p0_req_i,
  input  logic              p0_we_i,
  input  logic              p0_lock_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [DATA_W-1:0] p0_wdata_i,
  output logic              p0_gnt_o,
  output logic              p0_rvalid_o,
  output logic [DATA_W-1:0] p0_rdata_o,
  input  logic              p1_req_i,
  input  logic              p1_we_i,
  input  logic              p1_lock_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [DATA_W-1:0] p1_wdata_i,
  output logic              p1_gnt_o,
  output logic              p1_rvalid_o,
  output logic [DATA_W-1:0] p1_rdata_o,
  output logic              ram_rst_n_o,
  output logic              ram_wr_en_o,
  output logic              ram_rd_en_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wr_data_o,
  input  logic [DATA_W-1:0] ram_rd_data_i
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             last_q, last_d;      // 1 = port 1 served last
  logic [CNT_W-1:0] burst_q, burst_d;
  logic             p0_rvalid_q, p0_rvalid_d;
  logic             p1_rvalid_q, p1_rvalid_d;

  logic             gnt0, gnt1;
  logic             own_gnt;
  logic             lock_sel;
  logic [CNT_W-1:0] cnt_next;

  // Grant selection and next-state: the owner keeps priority while requesting,
  // otherwise fall through to normal arbitration in the same cycle.
  always_comb begin
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    own_gnt  = 1'b0;
    lock_sel = 1'b0;
    cnt_next = '0;
    state_d  = state_q;
    last_d   = last_q;
    burst_d  = burst_q;

    if (!rst_i) begin
      unique case (state_q)
        OWN0: if (p0_req_i) begin gnt0 = 1'b1; own_gnt = 1'b1; end
        OWN1: if (p1_req_i) begin gnt1 = 1'b1; own_gnt = 1'b1; end
        default: ;
      endcase

      if (!own_gnt) begin
        if (p0_req_i && p1_req_i) begin
`ifdef SP_RAM_ARB_FIXED_PRIO_EN
          gnt0 = 1'b1;
`else
          if (last_q) gnt0 = 1'b1;
          else        gnt1 = 1'b1;
`endif
        end else if (p0_req_i) begin
          gnt0 = 1'b1;
        end else if (p1_req_i) begin
          gnt1 = 1'b1;
        end
      end

      // Count includes the entering grant, so a fresh grant starts at 1.
      cnt_next = own_gnt ? burst_q + CNT_ONE : CNT_ONE;
      lock_sel = gnt0 ? p0_lock_i : p1_lock_i;

      if (gnt0 || gnt1) begin
        last_d = gnt1;
        if (lock_sel && (cnt_next < BURST_MAX)) begin
          state_d = gnt0 ? OWN0 : OWN1;
          burst_d = cnt_next;
        end else begin
          state_d = IDLE;
          burst_d = '0;
        end
      end else begin
        state_d = IDLE;
        burst_d = '0;
      end
    end
  end

  assign p0_rvalid_d = gnt0 & ~p0_we_i;
  assign p1_rvalid_d = gnt1 & ~p1_we_i;

  // State, round-robin pointer, burst counter and read-valid pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      burst_q     <= '0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      burst_q     <= burst_d;
      p0_rvalid_q <= p0_rvalid_d;
      p1_rvalid_q <= p1_rvalid_d;
    end
  end

  // RAM command mux: copy of the granted port, zeros when idle.
  always_comb begin
    ram_wr_en_o   = 1'b0;
    ram_rd_en_o   = 1'b0;
    ram_addr_o    = '0;
    ram_wr_data_o = '0;
    if (gnt0) begin
      ram_wr_en_o   = p0_we_i;
      ram_rd_en_o   = ~p0_we_i;
      ram_addr_o    = p0_addr_i;
      ram_wr_data_o = p0_wdata_i;
    end else if (gnt1) begin
      ram_wr_en_o   = p1_we_i;
      ram_rd_en_o   = ~p1_we_i;
      ram_addr_o    = p1_addr_i;
      ram_wr_data_o = p1_wdata_i;
    end
  end

  assign p0_gnt_o    = gnt0;
  assign p1_gnt_o    = gnt1;
  assign p0_rvalid_o = p0_rvalid_q;
  assign p1_rvalid_o = p1_rvalid_q;
  assign p0_rdata_o  = ram_rd_data_i;
  assign p1_rdata_o  = ram_rd_data_i;
  assign ram_rst_n_o = ~rst_i;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// tb_sp_ram_arbiter: directed bench for sp_ram_arbiter with a 128x8 RAM model.
module tb_sp_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       p0_req, p0_we, p0_lock, p1_req, p1_we, p1_lock;
  logic [6:0] p0_addr, p1_addr;
  logic [7:0] p0_wdata, p1_wdata;
  logic       p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [7:0] p0_rdata, p1_rdata;
  logic       ram_rst_n, ram_wr_en, ram_rd_en;
  logic [6:0] ram_addr;
  logic [7:0] ram_wr_data, ram_rd_data;

  logic [7:0] mem [128];

  int total = 0;
  int bad   = 0;

  sp_ram_arbiter #(.ADDR_W(7), .DATA_W(8), .MAX_BURST(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .p0_req_i(p0_req), .p0_we_i(p0_we), .p0_lock_i(p0_lock),
    .p0_addr_i(p0_addr), .p0_wdata_i(p0_wdata),
    .p0_gnt_o(p0_gnt), .p0_rvalid_o(p0_rvalid), .p0_rdata_o(p0_rdata),
    .p1_req_i(p1_req), .p1_we_i(p1_we), .p1_lock_i(p1_lock),
    .p1_addr_i(p1_addr), .p1_wdata_i(p1_wdata),
    .p1_gnt_o(p1_gnt), .p1_rvalid_o(p1_rvalid), .p1_rdata_o(p1_rdata),
    .ram_rst_n_o(ram_rst_n), .ram_wr_en_o(ram_wr_en), .ram_rd_en_o(ram_rd_en),
    .ram_addr_o(ram_addr), .ram_wr_data_o(ram_wr_data), .ram_rd_data_i(ram_rd_data)
  );

  always #5 clk = ~clk;

  // Single-port RAM with registered read; contents cleared while in reset.
  always @(posedge clk) begin
    if (!ram_rst_n) begin
      for (int i = 0; i < 128; i++) mem[i] <= 8'h00;
      ram_rd_data <= 8'h00;
    end else begin
      if (ram_wr_en) mem[ram_addr] <= ram_wr_data;
      if (ram_rd_en) ram_rd_data <= mem[ram_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic req, input logic we, input logic lock,
                      input logic [6:0] addr, input logic [7:0] wdata);
    p0_req = req; p0_we = we; p0_lock = lock; p0_addr = addr; p0_wdata = wdata;
  endtask

  task automatic drv1(input logic req, input logic we, input logic lock,
                      input logic [6:0] addr, input logic [7:0] wdata);
    p1_req = req; p1_we = we; p1_lock = lock; p1_addr = addr; p1_wdata = wdata;
  endtask

  // Expected winner of cycle i when both ports read continuously without lock.
  function automatic int exp2(input int i);
`ifdef SP_RAM_ARB_FIXED_PRIO_EN
    return 0;
`else
    return (i % 2 == 0) ? 1 : 0;
`endif
  endfunction

  int exp3 [7] = '{1, 1, 1, 1, 0, 1, 1};
  int prev_g;
  int g;
  int p1_cnt;
  bit p0_done;

  initial begin
    rst = 1'b1;
    drv0(1'b0, 1'b0, 1'b0, 7'h00, 8'h00);
    drv1(1'b0, 1'b0, 1'b0, 7'h00, 8'h00);
    tick();
    tick();

    // Reset state, with a request present to show it is ignored
    drv0(1'b1, 1'b0, 1'b0, 7'h10, 8'h00);
    #3;
    check("rst_gnt0", 32'(p0_gnt), 32'd0);
    check("rst_rd_en", 32'(ram_rd_en), 32'd0);
    check("rst_wr_en", 32'(ram_wr_en), 32'd0);
    check("rst_ram_rst_n", 32'(ram_rst_n), 32'd0);
    check("rst_rvalid0", 32'(p0_rvalid), 32'd0);
    check("rst_rvalid1", 32'(p1_rvalid), 32'd0);
    tick();
    rst = 1'b0;

    // Test 1: p0 write 0x15<-0xA5, then read it back
    drv0(1'b1, 1'b1, 1'b0, 7'h15, 8'hA5);
    #3;
    check("t1_ram_rst_n", 32'(ram_rst_n), 32'd1);
    check("t1_wr_gnt0", 32'(p0_gnt), 32'd1);
    check("t1_wr_en", 32'(ram_wr_en), 32'd1);
    check("t1_wr_addr", 32'(ram_addr), 32'h15);
    check("t1_wr_data", 32'(ram_wr_data), 32'hA5);
    tick();
    drv0(1'b1, 1'b0, 1'b0, 7'h15, 8'h00);
    #3;
    check("t1_rd_gnt0", 32'(p0_gnt), 32'd1);
    check("t1_rd_en", 32'(ram_rd_en), 32'd1);
    check("t1_wr_no_rvalid", 32'(p0_rvalid), 32'd0);
    tick();
    drv0(1'b0, 1'b0, 1'b0, 7'h00, 8'h00);
    #3;
    check("t1_rvalid0", 32'(p0_rvalid), 32'd1);
    check("t1_rdata0", 32'(p0_rdata), 32'hA5);
    check("t1_rvalid1", 32'(p1_rvalid), 32'd0);
    check("t1_idle_rd_en", 32'(ram_rd_en), 32'd0);
    check("t1_idle_addr", 32'(ram_addr), 32'd0);
    tick();

    // Test 2/6: both read continuously, no lock; last served was p0
    drv0(1'b1, 1'b0, 1'b0, 7'h15, 8'h00);
    drv1(1'b1, 1'b0, 1'b0, 7'h00, 8'h00);
    prev_g = -1;
    for (int i = 0; i < 6; i++) begin
      g = exp2(i);
      #3;
      check($sformatf("t2_gnt0_c%0d", i), 32'(p0_gnt), 32'(g == 0));
      check($sformatf("t2_gnt1_c%0d", i), 32'(p1_gnt), 32'(g == 1));
      check($sformatf("t2_rv0_c%0d", i), 32'(p0_rvalid), 32'(prev_g == 0));
      check($sformatf("t2_rv1_c%0d", i), 32'(p1_rvalid), 32'(prev_g == 1));
      if (prev_g == 0) check($sformatf("t2_rd0_c%0d", i), 32'(p0_rdata), 32'hA5);
      if (prev_g == 1) check($sformatf("t2_rd1_c%0d", i), 32'(p1_rdata), 32'h00);
      prev_g = g;
      tick();
    end
    // p0 drops: p1 finally gets the RAM
    drv0(1'b0, 1'b0, 1'b0, 7'h00, 8'h00);
    #3;
    check("t2_p1_after_drop", 32'(p1_gnt), 32'd1);
    check("t2_last_rv0", 32'(p0_rvalid), 32'd1);
    tick();
    drv1(1'b0, 1'b0, 1'b0, 7'h00, 8'h00);
    #3;
    check("t2_tail_rv1", 32'(p1_rvalid), 32'd1);
    check("t2_tail_rv0", 32'(p0_rvalid), 32'd0);
    tick();

    // Test 3: p1 locked burst of 6 reads, p0 joins on the second cycle
    p1_cnt  = 0;
    p0_done = 1'b0;
    for (int i = 0; i < 7; i++) begin
      drv0((i >= 1) && !p0_done, 1'b0, 1'b0, 7'h15, 8'h00);
      drv1(p1_cnt < 6, 1'b0, 1'b1, 7'h00, 8'h00);
      #3;
      check($sformatf("t3_gnt0_c%0d", i), 32'(p0_gnt), 32'(exp3[i] == 0));
      check($sformatf("t3_gnt1_c%0d", i), 32'(p1_gnt), 32'(exp3[i] == 1));
      if (exp3[i] == 0) p0_done = 1'b1;
      else              p1_cnt++;
      tick();
    end
    drv0(1'b0, 1'b0, 1'b0, 7'h00, 8'h00);
    drv1(1'b0, 1'b0, 1'b0, 7'h00, 8'h00);
    #3;
    check("t3_idle_gnt1", 32'(p1_gnt), 32'd0);
    tick();
    tick();

    // Test 4: write/read of same address from different ports, edge addresses
    drv1(1'b1, 1'b1, 1'b0, 7'h7F, 8'h3C);
    #3;
    check("t4_wr_gnt1", 32'(p1_gnt), 32'd1);
    check("t4_wr_addr7f", 32'(ram_addr), 32'h7F);
    tick();
    drv1(1'b0, 1'b0, 1'b0, 7'h00, 8'h00);
    drv0(1'b1, 1'b0, 1'b0, 7'h7F, 8'h00);
    #3;
    check("t4_rd_gnt0", 32'(p0_gnt), 32'd1);
    tick();
    drv0(1'b1, 1'b1, 1'b0, 7'h00, 8'h5A);
    #3;
    check("t4_rv0_7f", 32'(p0_rvalid), 32'd1);
    check("t4_rd0_7f", 32'(p0_rdata), 32'h3C);
    check("t4_wr0_gnt", 32'(p0_gnt), 32'd1);
    tick();
    drv0(1'b0, 1'b0, 1'b0, 7'h00, 8'h00);
    drv1(1'b1, 1'b0, 1'b0, 7'h00, 8'h00);
    #3;
    check("t4_rd_gnt1", 32'(p1_gnt), 32'd1);
    tick();
    drv1(1'b0, 1'b0, 1'b0, 7'h00, 8'h00);
    #3;
    check("t4_rv1_00", 32'(p1_rvalid), 32'd1);
    check("t4_rd1_00", 32'(p1_rdata), 32'h5A);
    check("t4_rv0_none", 32'(p0_rvalid), 32'd0);
    tick();

    // Test 5: reset in the cycle a p0 read is requested
    rst = 1'b1;
    drv0(1'b1, 1'b0, 1'b0, 7'h15, 8'h00);
    #3;
    check("t5_rst_gnt0", 32'(p0_gnt), 32'd0);
    check("t5_rst_rd_en", 32'(ram_rd_en), 32'd0);
    tick();
    rst = 1'b0;
    drv0(1'b0, 1'b0, 1'b0, 7'h00, 8'h00);
    #3;
    check("t5_no_rvalid0", 32'(p0_rvalid), 32'd0);
    tick();
    // First tie after reset goes to p0; RAM contents are cleared
    drv0(1'b1, 1'b0, 1'b0, 7'h15, 8'h00);
    drv1(1'b1, 1'b0, 1'b0, 7'h7F, 8'h00);
    #3;
    check("t5_tie_gnt0", 32'(p0_gnt), 32'd1);
    check("t5_tie_gnt1", 32'(p1_gnt), 32'd0);
    tick();
    drv0(1'b0, 1'b0, 1'b0, 7'h00, 8'h00);
    #3;
    check("t5_gnt1", 32'(p1_gnt), 32'd1);
    check("t5_rv0", 32'(p0_rvalid), 32'd1);
    check("t5_rd0_cleared", 32'(p0_rdata), 32'h00);
    tick();
    drv1(1'b0, 1'b0, 1'b0, 7'h00, 8'h00);
    #3;
    check("t5_rv1", 32'(p1_rvalid), 32'd1);
    check("t5_rd1_cleared", 32'(p1_rdata), 32'h00);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
